// File: rtl/ascon128_decrypt_2blocks.sv
// Ascon-128 authenticated decryption for one full AD block and one full
// ciphertext block, one permutation round per clock.
module ascon128_decrypt_2blocks #(
  parameter logic [63:0] IV = 64'h80400c0600000000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [127:0] SK,
  input  logic [127:0] N,
  input  logic [63:0]  A,
  input  logic [63:0]  C,
  input  logic [127:0] T,
  output logic [63:0]  P,
  output logic         BUSY,
  output logic         VALID,
  output logic         TAG_OK
);

  typedef enum logic [2:0] {IDLE, INIT, AD, PAD_AD, CT, FINAL, DONE} state_t;

  localparam logic [63:0] PAD = 64'h8000000000000000;

  state_t        state, state_nx;
  logic [3:0]    rnd, rnd_nx;
  logic [319:0]  s, s_nx, r;
  logic [127:0]  key_q, key_nx, t_q, t_nx, tag;
  logic [63:0]   a_q, a_nx, c_q, c_nx, pint, pint_nx, p_nx;
  logic          busy_nx, valid_nx, tagok_nx, match;

  // s = {x0,x1,x2,x3,x4}; the round constant for index i is {~i,i}
  function automatic logic [319:0] ascon_round(input logic [319:0] st, input logic [3:0] i);
    logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
    {a0, a1, a2, a3, a4} = st;
    a2 = a2 ^ {56'h0, ~i, i};
    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    a0 = a0 ^ {a0[18:0], a0[63:19]} ^ {a0[27:0], a0[63:28]};
    a1 = a1 ^ {a1[60:0], a1[63:61]} ^ {a1[38:0], a1[63:39]};
    a2 = a2 ^ {a2[0],    a2[63:1]}  ^ {a2[5:0],  a2[63:6]};
    a3 = a3 ^ {a3[9:0],  a3[63:10]} ^ {a3[16:0], a3[63:17]};
    a4 = a4 ^ {a4[6:0],  a4[63:7]}  ^ {a4[40:0], a4[63:41]};
    return {a0, a1, a2, a3, a4};
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      rnd    <= '0;
      s      <= '0;
      key_q  <= '0;
      a_q    <= '0;
      c_q    <= '0;
      t_q    <= '0;
      pint   <= '0;
      P      <= '0;
      BUSY   <= 1'b0;
      VALID  <= 1'b0;
      TAG_OK <= 1'b0;
    end else begin
      state  <= state_nx;
      rnd    <= rnd_nx;
      s      <= s_nx;
      key_q  <= key_nx;
      a_q    <= a_nx;
      c_q    <= c_nx;
      t_q    <= t_nx;
      pint   <= pint_nx;
      P      <= p_nx;
      BUSY   <= busy_nx;
      VALID  <= valid_nx;
      TAG_OK <= tagok_nx;
    end
  end

  // Every phase counts its round index up to 11; p6 phases start at 6
  always_comb begin
    state_nx = state;
    rnd_nx   = rnd;
    s_nx     = s;
    key_nx   = key_q;
    a_nx     = a_q;
    c_nx     = c_q;
    t_nx     = t_q;
    pint_nx  = pint;
    p_nx     = P;
    busy_nx  = BUSY;
    valid_nx = 1'b0;
    tagok_nx = TAG_OK;
    r        = ascon_round(s, rnd);
    tag      = r[127:0] ^ key_q;
    match    = (tag == t_q);
    case (state)
      IDLE: begin
        if (START) begin
          key_nx   = SK;
          a_nx     = A;
          c_nx     = C;
          t_nx     = T;
          s_nx     = {IV, SK, N};
          rnd_nx   = 4'd0;
          p_nx     = '0;
          tagok_nx = 1'b0;
          busy_nx  = 1'b1;
          state_nx = INIT;
        end
      end
      INIT, AD, PAD_AD, CT, FINAL: begin
        s_nx   = r;
        rnd_nx = rnd + 4'd1;
        if (rnd == 4'd11) begin
          rnd_nx = 4'd6;
          case (state)
            INIT: begin
              s_nx[127:0]   = r[127:0] ^ key_q;
              s_nx[319:256] = r[319:256] ^ a_q;
              state_nx      = AD;
            end
            AD: begin
              s_nx[319:256] = r[319:256] ^ PAD;
              state_nx      = PAD_AD;
            end
            PAD_AD: begin
              s_nx[0]       = ~r[0];
              pint_nx       = r[319:256] ^ c_q;
              s_nx[319:256] = c_q;
              state_nx      = CT;
            end
            CT: begin
              s_nx[319:256] = r[319:256] ^ PAD;
              s_nx[255:128] = r[255:128] ^ key_q;
              rnd_nx        = 4'd0;
              state_nx      = FINAL;
            end
            default: begin
              tagok_nx = match;
              p_nx     = match ? pint : 64'h0;
              state_nx = DONE;
            end
          endcase
        end
      end
      DONE: begin
        valid_nx = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon128_decrypt_2blocks.sv
// Testbench for ascon128_decrypt_2blocks: ciphertext/tag come from a sponge-level
// Ascon-128 encryption model using a table S-box.
module tb_ascon128_decrypt_2blocks;

  localparam logic [63:0]  IV   = 64'h80400c0600000000;
  localparam logic [127:0] KSEQ = 128'h000102030405060708090a0b0c0d0e0f;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         START = 1'b0;
  logic [127:0] SK = '0, N = '0, T = '0;
  logic [63:0]  A = '0, C = '0;
  logic [63:0]  P;
  logic         BUSY, VALID, TAG_OK;

  int testsRun = 0;
  int testsFailed = 0;

  ascon128_decrypt_2blocks #(.IV(IV)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SK(SK), .N(N), .A(A), .C(C), .T(T),
    .P(P), .BUSY(BUSY), .VALID(VALID), .TAG_OK(TAG_OK)
  );

  always #5 CLK = ~CLK;

  // Ascon S-box as a lookup table, x0 being the most significant bit
  function automatic logic [4:0] sbox(input logic [4:0] v);
    case (v)
      5'd0:  return 5'h04; 5'd1:  return 5'h0b; 5'd2:  return 5'h1f; 5'd3:  return 5'h14;
      5'd4:  return 5'h1a; 5'd5:  return 5'h15; 5'd6:  return 5'h09; 5'd7:  return 5'h02;
      5'd8:  return 5'h1b; 5'd9:  return 5'h05; 5'd10: return 5'h08; 5'd11: return 5'h12;
      5'd12: return 5'h1d; 5'd13: return 5'h03; 5'd14: return 5'h06; 5'd15: return 5'h1c;
      5'd16: return 5'h1e; 5'd17: return 5'h13; 5'd18: return 5'h07; 5'd19: return 5'h0e;
      5'd20: return 5'h00; 5'd21: return 5'h0d; 5'd22: return 5'h11; 5'd23: return 5'h18;
      5'd24: return 5'h10; 5'd25: return 5'h0c; 5'd26: return 5'h01; 5'd27: return 5'h19;
      5'd28: return 5'h16; 5'd29: return 5'h0a; 5'd30: return 5'h0f; default: return 5'h17;
    endcase
  endfunction

  function automatic logic [7:0] rconst(input int i);
    case (i)
      0: return 8'hf0; 1: return 8'he1; 2: return 8'hd2;  3: return 8'hc3;
      4: return 8'hb4; 5: return 8'ha5; 6: return 8'h96;  7: return 8'h87;
      8: return 8'h78; 9: return 8'h69; 10: return 8'h5a; default: return 8'h4b;
    endcase
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s, input int nr);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v, o;
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] = x[2] ^ {56'd0, rconst(r)};
      for (int b = 0; b < 64; b++) begin
        v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = sbox(v);
        for (int i = 0; i < 5; i++) y[i][b] = o[4-i];
      end
      x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
      x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
      x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
      x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
      x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic model_encrypt(input logic [127:0] k, input logic [127:0] n, input logic [63:0] a,
                               input logic [63:0] p, output logic [63:0] c, output logic [127:0] t);
    logic [319:0] s;
    s = perm({IV, k, n}, 12);
    s[127:0] = s[127:0] ^ k;
    s[319:256] = s[319:256] ^ a;
    s = perm(s, 6);
    s[319:256] = s[319:256] ^ 64'h8000000000000000;
    s = perm(s, 6);
    s[0] = ~s[0];
    s[319:256] = s[319:256] ^ p;
    c = s[319:256];
    s = perm(s, 6);
    s[319:256] = s[319:256] ^ 64'h8000000000000000;
    s[255:128] = s[255:128] ^ k;
    s = perm(s, 12);
    t = s[127:0] ^ k;
  endtask

  // Drives one decryption and records what the DUT shows on each cycle after the START edge
  task automatic run_dec(input logic [127:0] k, input logic [127:0] n, input logic [63:0] a,
                         input logic [63:0] c, input logic [127:0] t, input int againCyc,
                         input logic [127:0] altKey, output logic [63:0] pOut, output logic okOut,
                         output int vCyc, output int vPulses, output int busyBad,
                         output logic [63:0] pStart, output logic okStart);
    @(negedge CLK);
    SK = k; N = n; A = a; C = c; T = t; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    pStart = P; okStart = TAG_OK;
    busyBad = (BUSY !== 1'b1) ? 1 : 0;
    vCyc = -1; vPulses = 0; pOut = '0; okOut = 1'b0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(posedge CLK); #1;
      if (cyc == againCyc) begin
        START = 1'b1; SK = altKey; N = ~n; A = ~a; C = ~c; T = ~t;
      end else START = 1'b0;
      if (BUSY !== (cyc <= 42)) busyBad++;
      if (VALID === 1'b1) begin
        vPulses++;
        if (vCyc < 0) begin vCyc = cyc; pOut = P; okOut = TAG_OK; end
      end
    end
    START = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    testsRun++;
    if ({P, BUSY, VALID, TAG_OK} !== 67'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got P=%h BUSY=%b VALID=%b TAG_OK=%b expected all 0", P, BUSY, VALID, TAG_OK);
    end
    @(negedge CLK); RST = 1'b1;
  endtask

  task automatic test_zero_loopback;
    logic [63:0] c, p, ps; logic [127:0] t; logic ok, oks; int vc, vp, bb;
    model_encrypt('0, '0, '0, '0, c, t);
    run_dec('0, '0, '0, c, t, 0, '0, p, ok, vc, vp, bb, ps, oks);
    testsRun++;
    if (p !== 64'h0 || ok !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL zero_loopback: got P=%h TAG_OK=%b expected P=0 TAG_OK=1", p, ok);
    end
    testsRun++;
    if (vc !== 43 || vp !== 1) begin
      testsFailed++;
      $display("[TB] FAIL zero_valid_timing: got cycle=%0d pulses=%0d expected cycle=43 pulses=1", vc, vp);
    end
    testsRun++;
    if (bb !== 0) begin
      testsFailed++;
      $display("[TB] FAIL zero_busy_window: got %0d bad cycles expected 0", bb);
    end
  endtask

  task automatic test_known_vector;
    logic [63:0] c, p, ps; logic [127:0] t; logic ok, oks; int vc, vp, bb;
    model_encrypt(KSEQ, KSEQ, 64'h0001020304050607, 64'h08090a0b0c0d0e0f, c, t);
    run_dec(KSEQ, KSEQ, 64'h0001020304050607, c, t, 0, '0, p, ok, vc, vp, bb, ps, oks);
    testsRun++;
    if (p !== 64'h08090a0b0c0d0e0f || ok !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL known_vector: got P=%h TAG_OK=%b expected P=08090a0b0c0d0e0f TAG_OK=1", p, ok);
    end
    // Outputs must hold while idle, then clear when the next START is accepted
    repeat (5) @(posedge CLK);
    #1;
    testsRun++;
    if (P !== 64'h08090a0b0c0d0e0f || TAG_OK !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL hold_outputs: got P=%h TAG_OK=%b expected P=08090a0b0c0d0e0f TAG_OK=1", P, TAG_OK);
    end
    run_dec(KSEQ, KSEQ, 64'h0001020304050607, c, t ^ 128'h1, 0, '0, p, ok, vc, vp, bb, ps, oks);
    testsRun++;
    if (ps !== 64'h0 || oks !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL clear_on_start: got P=%h TAG_OK=%b expected 0 0", ps, oks);
    end
    testsRun++;
    if (p !== 64'h0 || ok !== 1'b0 || vc !== 43) begin
      testsFailed++;
      $display("[TB] FAIL tag_flip: got P=%h TAG_OK=%b cycle=%0d expected P=0 TAG_OK=0 cycle=43", p, ok, vc);
    end
    run_dec(KSEQ, KSEQ, 64'h0001020304050607, c ^ 64'h8000000000000000, t, 0, '0, p, ok, vc, vp, bb, ps, oks);
    testsRun++;
    if (p !== 64'h0 || ok !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ct_flip: got P=%h TAG_OK=%b expected P=0 TAG_OK=0", p, ok);
    end
  endtask

  task automatic test_random;
    logic [127:0] k, n, t; logic [63:0] a, pt, c, p, ps; logic ok, oks; int vc, vp, bb, bit_i;
    for (int it = 0; it < 6; it++) begin
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      n  = {$urandom(), $urandom(), $urandom(), $urandom()};
      a  = {$urandom(), $urandom()};
      pt = {$urandom(), $urandom()};
      model_encrypt(k, n, a, pt, c, t);
      run_dec(k, n, a, c, t, 0, '0, p, ok, vc, vp, bb, ps, oks);
      testsRun++;
      if (p !== pt || ok !== 1'b1 || vc !== 43) begin
        testsFailed++;
        $display("[TB] FAIL random_%0d: got P=%h TAG_OK=%b cycle=%0d expected P=%h TAG_OK=1 cycle=43", it, p, ok, vc, pt);
      end
      bit_i = int'($urandom_range(127, 0));
      t[bit_i] = ~t[bit_i];
      run_dec(k, n, a, c, t, 0, '0, p, ok, vc, vp, bb, ps, oks);
      testsRun++;
      if (p !== 64'h0 || ok !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL random_badtag_%0d: got P=%h TAG_OK=%b expected P=0 TAG_OK=0", it, p, ok);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] c, p, ps; logic [127:0] t; logic ok, oks; int vc, vp, bb;
    model_encrypt(KSEQ, KSEQ, 64'h0001020304050607, 64'h08090a0b0c0d0e0f, c, t);
    run_dec(KSEQ, KSEQ, 64'h0001020304050607, c, t, 10, ~KSEQ, p, ok, vc, vp, bb, ps, oks);
    testsRun++;
    if (p !== 64'h08090a0b0c0d0e0f || ok !== 1'b1 || vp !== 1 || vc !== 43) begin
      testsFailed++;
      $display("[TB] FAIL start_while_busy: got P=%h TAG_OK=%b pulses=%0d cycle=%0d expected P=08090a0b0c0d0e0f TAG_OK=1 pulses=1 cycle=43",
               p, ok, vp, vc);
    end
  endtask

  task automatic test_reset_abort;
    logic [63:0] c, p, ps; logic [127:0] t; logic ok, oks; int vc, vp, bb, stray;
    model_encrypt(KSEQ, KSEQ, 64'h0001020304050607, 64'h08090a0b0c0d0e0f, c, t);
    @(negedge CLK);
    SK = KSEQ; N = KSEQ; A = 64'h0001020304050607; C = c; T = t; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (20) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    testsRun++;
    if ({P, BUSY, VALID, TAG_OK} !== 67'h0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got P=%h BUSY=%b VALID=%b TAG_OK=%b expected all 0", P, BUSY, VALID, TAG_OK);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    stray = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge CLK); #1;
      if (VALID !== 1'b0 || BUSY !== 1'b0) stray++;
    end
    testsRun++;
    if (stray !== 0) begin
      testsFailed++;
      $display("[TB] FAIL abort_no_valid: got %0d active cycles expected 0", stray);
    end
    run_dec(KSEQ, KSEQ, 64'h0001020304050607, c, t, 0, '0, p, ok, vc, vp, bb, ps, oks);
    testsRun++;
    if (p !== 64'h08090a0b0c0d0e0f || ok !== 1'b1 || vc !== 43) begin
      testsFailed++;
      $display("[TB] FAIL after_reset_run: got P=%h TAG_OK=%b cycle=%0d expected P=08090a0b0c0d0e0f TAG_OK=1 cycle=43", p, ok, vc);
    end
  endtask

  initial begin
    test_reset();
    test_zero_loopback();
    test_known_vector();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
